param_store_buffer: RTL and testbench

PARAM_STORE_BUFFER -- requirements
Module: param_store_buffer

---
 rtl/param_store_buffer_if.sv | 32 +++
 rtl/param_store_buffer.sv | 188 ++++++++++++++++++
 tb/tb_param_store_buffer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/param_store_buffer_if.sv
// Store push and cache write-port bundle for param_store_buffer.
// slave is the buffer side, master is the producer / cache side.
interface param_store_buffer_if #(
    parameter int AW = 64,
    parameter int DW = 64
) ();
    logic            valid_i;
    logic            ready_o;
    logic [AW-1:0]   paddr_i;
    logic [DW-1:0]   data_i;
    logic [DW/8-1:0] be_i;
    logic [1:0]      size_i;

    logic            mem_req_o;
    logic            mem_gnt_i;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic [DW/8-1:0] mem_be_o;
    logic [1:0]      mem_size_o;

    modport slave (
        input  valid_i, paddr_i, data_i, be_i, size_i, mem_gnt_i,
        output ready_o, mem_req_o, mem_addr_o, mem_wdata_o,
        output mem_be_o, mem_size_o
    );

    modport master (
        output valid_i, paddr_i, data_i, be_i, size_i, mem_gnt_i,
        input  ready_o, mem_req_o, mem_addr_o, mem_wdata_o,
        input  mem_be_o, mem_size_o
    );
endinterface

// File: rtl/param_store_buffer.sv
// Two-level store buffer: speculative FIFO feeding a commit FIFO that drains to the cache.
// Define STORE_BUF_FWD_EN to build the store-to-load forwarding path.
module param_store_buffer #(
    parameter int AW           = 64,
    parameter int DW           = 64,
    parameter int SPEC_DEPTH   = 4,
    parameter int COMMIT_DEPTH = 8,
    parameter int CMP_LSB      = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    param_store_buffer_if.slave             bus,
    input  logic                            commit_i,
    output logic                            commit_ready_o,
    input  logic [11:0]                     page_offset_i,
    output logic                            offset_match_o,
    input  logic [AW-1:0]                   ld_paddr_i,
    input  logic [DW/8-1:0]                 ld_be_i,
    output logic                            fwd_hit_o,
    output logic [DW-1:0]                   fwd_data_o,
    output logic                            no_st_pending_o,
    output logic [$clog2(SPEC_DEPTH):0]     spec_cnt_o,
    output logic [$clog2(COMMIT_DEPTH):0]   commit_cnt_o
);
    localparam int SW = $clog2(SPEC_DEPTH);
    localparam int CW = $clog2(COMMIT_DEPTH);
    localparam int BW = DW / 8;
    localparam logic [SW:0] SPEC_MAX = (SW+1)'(SPEC_DEPTH);
    localparam logic [CW:0] CMT_MAX  = (CW+1)'(COMMIT_DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
        logic [1:0]    size;
    } entry_t;

    entry_t                  spec_q [SPEC_DEPTH];
    entry_t                  cmt_q  [COMMIT_DEPTH];
    logic [SPEC_DEPTH-1:0]   spec_vld;
    logic [COMMIT_DEPTH-1:0] cmt_vld;
    logic [SW-1:0]           spec_wptr, spec_rptr, spec_rptr_n;
    logic [CW-1:0]           cmt_wptr, cmt_rptr;
    logic [SW:0]             spec_cnt, spec_cnt_n;
    logic [CW:0]             cmt_cnt, cmt_cnt_n;
    logic                    push, commit_fire, pop;
    entry_t                  cmt_head;

    assign bus.mem_req_o   = (cmt_cnt != '0);
    assign pop             = bus.mem_req_o & bus.mem_gnt_i;
    assign commit_ready_o  = (spec_cnt != '0) &
                             ((cmt_cnt < CMT_MAX) | pop);
    assign commit_fire     = commit_i & commit_ready_o;
    assign bus.ready_o     = (spec_cnt < SPEC_MAX) | commit_fire;
    // Stores presented during a flush belong to the squashed path.
    assign push            = bus.valid_i & bus.ready_o & ~flush_i;

    assign cmt_head        = cmt_q[cmt_rptr];
    assign bus.mem_addr_o  = cmt_head.addr;
    assign bus.mem_wdata_o = cmt_head.data;
    assign bus.mem_be_o    = cmt_head.be;
    assign bus.mem_size_o  = cmt_head.size;

    assign no_st_pending_o = (cmt_cnt == '0);
    assign spec_cnt_o      = spec_cnt;
    assign commit_cnt_o    = cmt_cnt;

    always_comb begin
        spec_rptr_n = spec_rptr;
        if (commit_fire) spec_rptr_n = spec_rptr + SW'(1);
        spec_cnt_n = spec_cnt;
        if (push && !commit_fire) spec_cnt_n = spec_cnt + (SW+1)'(1);
        else if (!push && commit_fire) spec_cnt_n = spec_cnt - (SW+1)'(1);
        if (flush_i) spec_cnt_n = '0;
        cmt_cnt_n = cmt_cnt;
        if (commit_fire && !pop) cmt_cnt_n = cmt_cnt + (CW+1)'(1);
        else if (!commit_fire && pop) cmt_cnt_n = cmt_cnt - (CW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spec_vld  <= '0;
            cmt_vld   <= '0;
            spec_wptr <= '0;
            spec_rptr <= '0;
            cmt_wptr  <= '0;
            cmt_rptr  <= '0;
            spec_cnt  <= '0;
            cmt_cnt   <= '0;
        end else begin
            if (pop) begin
                cmt_vld[cmt_rptr] <= 1'b0;
                cmt_rptr          <= cmt_rptr + CW'(1);
            end
            if (commit_fire) begin
                spec_vld[spec_rptr] <= 1'b0;
                cmt_vld[cmt_wptr]   <= 1'b1;
                cmt_wptr            <= cmt_wptr + CW'(1);
            end
            if (push) begin
                spec_vld[spec_wptr] <= 1'b1;
                spec_wptr           <= spec_wptr + SW'(1);
            end
            if (flush_i) begin
                spec_vld  <= '0;
                spec_wptr <= spec_rptr_n;
            end
            spec_rptr <= spec_rptr_n;
            spec_cnt  <= spec_cnt_n;
            cmt_cnt   <= cmt_cnt_n;
        end
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            spec_q[spec_wptr] <= '{addr: bus.paddr_i, data: bus.data_i,
                                   be: bus.be_i, size: bus.size_i};
        end
        if (commit_fire) cmt_q[cmt_wptr] <= spec_q[spec_rptr];
    end

    always_comb begin
        offset_match_o = bus.valid_i &
            (bus.paddr_i[11:CMP_LSB] == page_offset_i[11:CMP_LSB]);
        for (int i = 0; i < SPEC_DEPTH; i++) begin
            if (spec_vld[i] &&
                spec_q[i].addr[11:CMP_LSB] == page_offset_i[11:CMP_LSB])
                offset_match_o = 1'b1;
        end
        for (int i = 0; i < COMMIT_DEPTH; i++) begin
            if (cmt_vld[i] &&
                cmt_q[i].addr[11:CMP_LSB] == page_offset_i[11:CMP_LSB])
                offset_match_o = 1'b1;
        end
    end

    logic unused_offset_lsb;
    assign unused_offset_lsb = ^page_offset_i[CMP_LSB-1:0];

`ifdef STORE_BUF_FWD_EN
    logic [BW-1:0] fwd_cov;
    logic [CW-1:0] cidx;
    logic [SW-1:0] sidx;
    logic          unused_ld_lsb;

    assign unused_ld_lsb = ^ld_paddr_i[CMP_LSB-1:0];

    // Walk oldest to newest, commit queue first, so younger lanes overwrite.
    always_comb begin
        fwd_cov    = '0;
        fwd_data_o = '0;
        cidx       = '0;
        sidx       = '0;
        for (int i = 0; i < COMMIT_DEPTH; i++) begin
            cidx = cmt_rptr + CW'(i);
            if (cmt_vld[cidx] &&
                cmt_q[cidx].addr[AW-1:CMP_LSB] == ld_paddr_i[AW-1:CMP_LSB]) begin
                for (int b = 0; b < BW; b++) begin
                    if (cmt_q[cidx].be[b]) begin
                        fwd_cov[b]          = 1'b1;
                        fwd_data_o[8*b +: 8] = cmt_q[cidx].data[8*b +: 8];
                    end
                end
            end
        end
        for (int i = 0; i < SPEC_DEPTH; i++) begin
            sidx = spec_rptr + SW'(i);
            if (spec_vld[sidx] &&
                spec_q[sidx].addr[AW-1:CMP_LSB] == ld_paddr_i[AW-1:CMP_LSB]) begin
                for (int b = 0; b < BW; b++) begin
                    if (spec_q[sidx].be[b]) begin
                        fwd_cov[b]          = 1'b1;
                        fwd_data_o[8*b +: 8] = spec_q[sidx].data[8*b +: 8];
                    end
                end
            end
        end
        fwd_hit_o = (ld_be_i != '0) && ((ld_be_i & ~fwd_cov) == '0);
    end
`else
    logic unused_ld;
    assign unused_ld  = ^{ld_paddr_i, ld_be_i};
    assign fwd_hit_o  = 1'b0;
    assign fwd_data_o = '0;
`endif
endmodule

// File: tb/tb_param_store_buffer.sv
// Directed bench for param_store_buffer: fill, commit stall, flush,
// drain, throughput, forwarding and reset-abandon cases.
module tb_param_store_buffer;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        commit_i;
    logic        commit_ready_o;
    logic [11:0] page_offset_i;
    logic        offset_match_o;
    logic [63:0] ld_paddr_i;
    logic [7:0]  ld_be_i;
    logic        fwd_hit_o;
    logic [63:0] fwd_data_o;
    logic        no_st_pending_o;
    logic [2:0]  spec_cnt_o;
    logic [3:0]  commit_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    param_store_buffer_if #(.AW(64), .DW(64)) bus ();

    param_store_buffer #(
        .AW(64), .DW(64), .SPEC_DEPTH(4), .COMMIT_DEPTH(8), .CMP_LSB(3)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .bus            (bus),
        .commit_i       (commit_i),
        .commit_ready_o (commit_ready_o),
        .page_offset_i  (page_offset_i),
        .offset_match_o (offset_match_o),
        .ld_paddr_i     (ld_paddr_i),
        .ld_be_i        (ld_be_i),
        .fwd_hit_o      (fwd_hit_o),
        .fwd_data_o     (fwd_data_o),
        .no_st_pending_o(no_st_pending_o),
        .spec_cnt_o     (spec_cnt_o),
        .commit_cnt_o   (commit_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] a,
                         input logic [63:0] d, input logic [7:0] be);
        bus.valid_i = v;
        bus.paddr_i = a;
        bus.data_i  = d;
        bus.be_i    = be;
        bus.size_i  = 2'd3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; commit_i = 1'b0;
        page_offset_i = 12'h0; ld_paddr_i = '0; ld_be_i = '0;
        drive(1'b0, 64'h0, 64'h0, 8'h0);
        bus.mem_gnt_i = 1'b0;
        #12;
        chk("rst_ready", bus.ready_o, 1);
        chk("rst_commit_ready", commit_ready_o, 0);
        chk("rst_mem_req", bus.mem_req_o, 0);
        chk("rst_offset_match", offset_match_o, 0);
        chk("rst_fwd_hit", fwd_hit_o, 0);
        chk("rst_fwd_data", fwd_data_o, 0);
        chk("rst_no_pending", no_st_pending_o, 1);
        chk("rst_spec_cnt", spec_cnt_o, 0);
        chk("rst_commit_cnt", commit_cnt_o, 0);
        rst_ni = 1'b1;
        step();

        // Fill the speculative queue without committing.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h1000 + 64'(8 * i), 64'(i + 1), 8'hFF);
            #1 chk("fill_ready", bus.ready_o, 1);
            step();
        end
        drive(1'b1, 64'h1020, 64'h99, 8'hFF);
        page_offset_i = 12'h020;
        #1;
        chk("full_ready", bus.ready_o, 0);
        chk("full_spec_cnt", spec_cnt_o, 4);
        chk("om_from_paddr", offset_match_o, 1);
        step();
        chk("fifth_dropped_cnt", spec_cnt_o, 4);
        bus.valid_i = 1'b0;
        #1 chk("fifth_dropped_om", offset_match_o, 0);
        page_offset_i = 12'h008;
        #1 chk("om_spec_entry", offset_match_o, 1);
        chk("commit_ready_spec", commit_ready_o, 1);
        chk("no_req_yet", bus.mem_req_o, 0);

        // Commit eight stores against a stalled cache.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 64'h1020 + 64'(8 * k), 64'(k + 5), 8'hFF);
            commit_i = 1'b1;
            #1;
            chk("stall_commit_ready", commit_ready_o, 1);
            chk("stall_push_ready", bus.ready_o, 1);
            if (k > 0) chk("stall_addr_stable", bus.mem_addr_o, 64'h1000);
            step();
        end
        drive(1'b1, 64'h1060, 64'h77, 8'hFF);
        #1;
        chk("stall_commit_cnt", commit_cnt_o, 8);
        chk("stall_commit_blocked", commit_ready_o, 0);
        chk("stall_push_blocked", bus.ready_o, 0);
        chk("stall_req", bus.mem_req_o, 1);
        chk("stall_addr", bus.mem_addr_o, 64'h1000);
        step();
        chk("stall_spec_cnt", spec_cnt_o, 4);
        bus.valid_i = 1'b0;
        bus.mem_gnt_i = 1'b1;
        #1 chk("gnt_commit_ready", commit_ready_o, 1);
        step();
        chk("pop_commit_cnt", commit_cnt_o, 8);
        chk("pop_spec_cnt", spec_cnt_o, 3);
        chk("pop_next_addr", bus.mem_addr_o, 64'h1008);
        chk("pop_next_data", bus.mem_wdata_o, 64'h2);

        // Flush with a commit and a dropped push in the same cycle.
        flush_i = 1'b1;
        drive(1'b1, 64'h3000, 64'h5, 8'hFF);
        #1 chk("flush_commit_ready", commit_ready_o, 1);
        step();
        flush_i = 1'b0; commit_i = 1'b0; bus.mem_gnt_i = 1'b0;
        bus.valid_i = 1'b0;
        page_offset_i = 12'h050;
        #1;
        chk("flush_spec_cnt", spec_cnt_o, 0);
        chk("flush_commit_cnt", commit_cnt_o, 8);
        chk("flush_head_addr", bus.mem_addr_o, 64'h1010);
        chk("flush_om_050", offset_match_o, 0);
        page_offset_i = 12'h058;
        #1 chk("flush_om_058", offset_match_o, 0);
        page_offset_i = 12'h000;
        #1 chk("flush_dropped_push", offset_match_o, 0);
        page_offset_i = 12'h048;
        #1 chk("flush_committed_om", offset_match_o, 1);
        chk("flush_ready", bus.ready_o, 1);

        // Drain the commit queue in order.
        bus.mem_gnt_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drain_req", bus.mem_req_o, 1);
            chk("drain_addr", bus.mem_addr_o, 64'h1010 + 64'(8 * i));
            step();
        end
        chk("drain_no_pending", no_st_pending_o, 1);
        chk("drain_commit_cnt", commit_cnt_o, 0);
        chk("drain_req_low", bus.mem_req_o, 0);

        // One store per cycle with push, commit and grant every cycle.
        for (int k = 0; k < 8; k++) begin
            drive(k < 6, 64'h1000 + 64'(8 * k), 64'(k), 8'hFF);
            commit_i = 1'b1;
            #1;
            chk("tput_ready", bus.ready_o, 1);
            if (k >= 2) begin
                chk("tput_req", bus.mem_req_o, 1);
                chk("tput_addr", bus.mem_addr_o, 64'h1000 + 64'(8 * (k - 2)));
            end
            step();
        end
        commit_i = 1'b0; bus.valid_i = 1'b0; bus.mem_gnt_i = 1'b0;
        #1;
        chk("tput_no_pending", no_st_pending_o, 1);
        chk("tput_spec_cnt", spec_cnt_o, 0);

        // Byte-lane forwarding, younger store overriding one lane.
        drive(1'b1, 64'h2000, 64'h1122334455667788, 8'h0F);
        step();
        drive(1'b1, 64'h2000, 64'h00000000000000AA, 8'h01);
        step();
        bus.valid_i = 1'b0;
        ld_paddr_i = 64'h2000; ld_be_i = 8'h0F;
        #1;
`ifdef STORE_BUF_FWD_EN
        chk("fwd_hit_0f", fwd_hit_o, 1);
        chk("fwd_data_0f", 64'(fwd_data_o[31:0]), 64'h556677AA);
`else
        chk("fwd_off_hit", fwd_hit_o, 0);
        chk("fwd_off_data", fwd_data_o, 0);
`endif
        ld_be_i = 8'hFF;
        #1 chk("fwd_miss_ff", fwd_hit_o, 0);
        ld_paddr_i = 64'h2008; ld_be_i = 8'h01;
        #1 chk("fwd_miss_addr", fwd_hit_o, 0);
        commit_i = 1'b1;
        step();
        commit_i = 1'b0;
        ld_paddr_i = 64'h2000; ld_be_i = 8'h0F;
        #1;
`ifdef STORE_BUF_FWD_EN
        chk("fwd_cross_hit", fwd_hit_o, 1);
        chk("fwd_cross_data", 64'(fwd_data_o[31:0]), 64'h556677AA);
`else
        chk("fwd_off_cross_hit", fwd_hit_o, 0);
`endif
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;

        // Reset while a request waits for a grant.
        drive(1'b1, 64'h4000, 64'h1, 8'hFF);
        step();
        drive(1'b1, 64'h4008, 64'h2, 8'hFF);
        step();
        bus.valid_i = 1'b0;
        commit_i = 1'b1;
        step();
        step();
        commit_i = 1'b0;
        #1;
        chk("pre_rst_commit_cnt", commit_cnt_o, 3);
        chk("pre_rst_req", bus.mem_req_o, 1);
        chk("pre_rst_addr", bus.mem_addr_o, 64'h2000);
        rst_ni = 1'b0;
        #1;
        chk("rst_abandon_req", bus.mem_req_o, 0);
        chk("rst_abandon_pending", no_st_pending_o, 1);
        step();
        chk("rst_hold_req", bus.mem_req_o, 0);
        rst_ni = 1'b1;
        step();
        chk("post_rst_req", bus.mem_req_o, 0);
        chk("post_rst_commit_cnt", commit_cnt_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
